controller_sequencer: RTL and testbench



---
 rtl/controller_sequencer_if.sv | 36 +++
 rtl/controller_sequencer.sv | 146 ++++++++++++++
 tb/tb_controller_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/controller_sequencer_if.sv
// Control bundle between the SAP sequencer and the registers, PC, RAM and ALU it steers.
// The master side is the sequencer: it reads the IR opcode and drives the T-state ring and every enable.
interface controller_sequencer_if #(
    parameter int NUM_T    = 6,
    parameter int OP_WIDTH = 4
);
    logic [OP_WIDTH-1:0] opcode;
    logic [NUM_T-1:0]    t_state;
    logic                pc_inc;
    logic                low_pc_o_en;
    logic                low_mar_i_en;
    logic                low_ram_o_en;
    logic                low_ir_i_en;
    logic                low_ir_o_en;
    logic                low_a_i_en;
    logic                low_a_o_en;
    logic                low_b_i_en;
    logic                low_alu_o_en;
    logic                alu_sub;
    logic                low_out_i_en;
    logic                halt;

    modport master (
        input  opcode,
        output t_state, pc_inc, low_pc_o_en, low_mar_i_en, low_ram_o_en, low_ir_i_en,
               low_ir_o_en, low_a_i_en, low_a_o_en, low_b_i_en, low_alu_o_en, alu_sub,
               low_out_i_en, halt
    );

    modport slave (
        output opcode,
        input  t_state, pc_inc, low_pc_o_en, low_mar_i_en, low_ram_o_en, low_ir_i_en,
               low_ir_o_en, low_a_i_en, low_a_o_en, low_b_i_en, low_alu_o_en, alu_sub,
               low_out_i_en, halt
    );
endinterface

// File: rtl/controller_sequencer.sv
// SAP controller/sequencer: one-hot T1..T6 ring plus opcode decode into bus load/output enables.
// Define CYCLE_SKIP_EN to return to T1 right after an instruction's last active T-state.
module controller_sequencer #(
    parameter int NUM_T    = 6,
    parameter int OP_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   sync_reset,
    controller_sequencer_if.master bus
);

    localparam logic [OP_WIDTH-1:0] OP_LDA = OP_WIDTH'(4'b0000);
    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(4'b0001);
    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(4'b0010);
    localparam logic [OP_WIDTH-1:0] OP_OUT = OP_WIDTH'(4'b1110);
    localparam logic [OP_WIDTH-1:0] OP_HLT = OP_WIDTH'(4'b1111);

    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    localparam logic [NUM_T-1:0] RING_T1 = NUM_T'(1);

    logic [NUM_T-1:0] t_q;
    logic [NUM_T-1:0] t_next;
    logic             halt_q;

    // Active-high internal enables; inverted onto the active-low bus controls at the end.
    logic pc_inc_c;
    logic pc_o_c;
    logic mar_i_c;
    logic ram_o_c;
    logic ir_i_c;
    logic ir_o_c;
    logic a_i_c;
    logic a_o_c;
    logic b_i_c;
    logic alu_o_c;
    logic alu_sub_c;
    logic out_i_c;

    logic is_add_sub;

    assign is_add_sub = (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB);

    // Next ring position: plain rotate, optionally short-circuited back to T1.
    always_comb begin
        t_next = {t_q[NUM_T-2:0], t_q[NUM_T-1]};
`ifdef CYCLE_SKIP_EN
        if (t_q[T5] && (bus.opcode == OP_LDA)) begin
            t_next = RING_T1;
        end
        if (t_q[T4] && !(bus.opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_HLT})) begin
            t_next = RING_T1;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            t_q    <= RING_T1;
            halt_q <= 1'b0;
        end else if (!halt_q) begin
            if (t_q[T4] && (bus.opcode == OP_HLT)) begin
                halt_q <= 1'b1;
            end
            t_q <= t_next;
        end
    end

    // NOTE: every enable gets a default before the decode, so no path leaves one unassigned (no latch).
    always_comb begin
        pc_inc_c  = 1'b0;
        pc_o_c    = 1'b0;
        mar_i_c   = 1'b0;
        ram_o_c   = 1'b0;
        ir_i_c    = 1'b0;
        ir_o_c    = 1'b0;
        a_i_c     = 1'b0;
        a_o_c     = 1'b0;
        b_i_c     = 1'b0;
        alu_o_c   = 1'b0;
        alu_sub_c = 1'b0;
        out_i_c   = 1'b0;

        if (!sync_reset && !halt_q) begin
            if (t_q[T1]) begin
                pc_o_c  = 1'b1;
                mar_i_c = 1'b1;
            end
            if (t_q[T2]) begin
                pc_inc_c = 1'b1;
            end
            if (t_q[T3]) begin
                ram_o_c = 1'b1;
                ir_i_c  = 1'b1;
            end
            if (t_q[T4]) begin
                if ((bus.opcode == OP_LDA) || is_add_sub) begin
                    ir_o_c  = 1'b1;
                    mar_i_c = 1'b1;
                end else if (bus.opcode == OP_OUT) begin
                    a_o_c   = 1'b1;
                    out_i_c = 1'b1;
                end
            end
            if (t_q[T5]) begin
                if (bus.opcode == OP_LDA) begin
                    ram_o_c = 1'b1;
                    a_i_c   = 1'b1;
                end else if (is_add_sub) begin
                    ram_o_c = 1'b1;
                    b_i_c   = 1'b1;
                end
            end
            if (t_q[T6] && is_add_sub) begin
                alu_o_c = 1'b1;
                a_i_c   = 1'b1;
            end
            // Subtract select is held across the whole execute phase so the ALU output is stable by T6.
            if ((bus.opcode == OP_SUB) && (t_q[T4] || t_q[T5] || t_q[T6])) begin
                alu_sub_c = 1'b1;
            end
        end
    end

    assign bus.t_state      = t_q;
    assign bus.halt         = halt_q;
    assign bus.pc_inc       = pc_inc_c;
    assign bus.alu_sub      = alu_sub_c;
    assign bus.low_pc_o_en  = ~pc_o_c;
    assign bus.low_mar_i_en = ~mar_i_c;
    assign bus.low_ram_o_en = ~ram_o_c;
    assign bus.low_ir_i_en  = ~ir_i_c;
    assign bus.low_ir_o_en  = ~ir_o_c;
    assign bus.low_a_i_en   = ~a_i_c;
    assign bus.low_a_o_en   = ~a_o_c;
    assign bus.low_b_i_en   = ~b_i_c;
    assign bus.low_alu_o_en = ~alu_o_c;
    assign bus.low_out_i_en = ~out_i_c;

endmodule

// File: tb/tb_controller_sequencer.sv
// Self-checking bench for controller_sequencer: directed instruction sequences then random programs,
// compared against a step-counter model of the instruction table. Honours CYCLE_SKIP_EN like the RTL.
module tb_controller_sequencer;

    localparam logic [3:0] LDA = 4'b0000;
    localparam logic [3:0] ADD = 4'b0001;
    localparam logic [3:0] SUB = 4'b0010;
    localparam logic [3:0] OUT = 4'b1110;
    localparam logic [3:0] HLT = 4'b1111;
    localparam logic [3:0] UND = 4'b0101;

    // Expected-control bit positions (active high).
    localparam logic [11:0] E_PC_INC  = 12'h800;
    localparam logic [11:0] E_PC_O    = 12'h400;
    localparam logic [11:0] E_MAR_I   = 12'h200;
    localparam logic [11:0] E_RAM_O   = 12'h100;
    localparam logic [11:0] E_IR_I    = 12'h080;
    localparam logic [11:0] E_IR_O    = 12'h040;
    localparam logic [11:0] E_A_I     = 12'h020;
    localparam logic [11:0] E_A_O     = 12'h010;
    localparam logic [11:0] E_B_I     = 12'h008;
    localparam logic [11:0] E_ALU_O   = 12'h004;
    localparam logic [11:0] E_ALU_SUB = 12'h002;
    localparam logic [11:0] E_OUT_I   = 12'h001;

    logic clk;
    logic sync_reset;

    controller_sequencer_if #(.NUM_T(6), .OP_WIDTH(4)) bus ();

    controller_sequencer #(.NUM_T(6), .OP_WIDTH(4)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: k = current step of the instruction (1..6), halted = processor stopped.
    int k      = 1;
    bit halted = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] exp_ctrl(input int step, input logic [3:0] op,
                                             input bit hl, input bit r);
        logic [11:0] v;
        v = '0;
        if (r || hl) return v;
        case (step)
            1: v = E_PC_O | E_MAR_I;
            2: v = E_PC_INC;
            3: v = E_RAM_O | E_IR_I;
            default: begin
                if (op == LDA) begin
                    if (step == 4) v = E_IR_O | E_MAR_I;
                    if (step == 5) v = E_RAM_O | E_A_I;
                end else if (op == ADD || op == SUB) begin
                    if (step == 4) v = E_IR_O | E_MAR_I;
                    if (step == 5) v = E_RAM_O | E_B_I;
                    if (step == 6) v = E_ALU_O | E_A_I;
                    if (op == SUB) v = v | E_ALU_SUB;
                end else if (op == OUT) begin
                    if (step == 4) v = E_A_O | E_OUT_I;
                end
            end
        endcase
        return v;
    endfunction

    function automatic logic [11:0] obs_ctrl();
        return {bus.pc_inc, ~bus.low_pc_o_en, ~bus.low_mar_i_en, ~bus.low_ram_o_en,
                ~bus.low_ir_i_en, ~bus.low_ir_o_en, ~bus.low_a_i_en, ~bus.low_a_o_en,
                ~bus.low_b_i_en, ~bus.low_alu_o_en, bus.alu_sub, ~bus.low_out_i_en};
    endfunction

    function automatic int instr_len(input logic [3:0] op);
`ifdef CYCLE_SKIP_EN
        if (op == LDA) return 5;
        if (!(op inside {LDA, ADD, SUB, HLT})) return 4;
`endif
        return 6;
    endfunction

    task automatic model_step(input bit r, input logic [3:0] op);
        if (r) begin
            k      = 1;
            halted = 1'b0;
        end else if (!halted) begin
            if (k == 4 && op == HLT) halted = 1'b1;
            k = (k >= instr_len(op)) ? 1 : k + 1;
        end
    endtask

    // Drive inputs, check every output mid-cycle, then advance one clock with the model.
    task automatic tick(input bit r, input logic [3:0] op);
        logic [4:0] drivers;
        sync_reset = r;
        bus.opcode = op;
        #1;
        drivers = {~bus.low_pc_o_en, ~bus.low_ram_o_en, ~bus.low_ir_o_en,
                   ~bus.low_a_o_en, ~bus.low_alu_o_en};
        check($sformatf("t_state T%0d op%0h", k, op), 32'(bus.t_state), 32'(1) << (k - 1));
        check($sformatf("halt T%0d op%0h", k, op), 32'(bus.halt), 32'(halted));
        check($sformatf("ctrl T%0d op%0h rst%0d", k, op, r), 32'(obs_ctrl()),
              32'(exp_ctrl(k, op, halted, r)));
        check("onehot", 32'($onehot(bus.t_state)), 32'(1));
        check("bus_drivers", 32'($countones(drivers) <= 1), 32'(1));
        check("pc_inc_with_pc_o", 32'(bus.pc_inc && !bus.low_pc_o_en), 32'(0));
        @(posedge clk);
        model_step(r, op);
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [3:0] op);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, op);
            if (k == 1 || halted) break;
        end
    endtask

    initial begin
        logic [3:0] op;
        int         hcnt;

        sync_reset = 1'b1;
        bus.opcode = LDA;
        repeat (2) @(negedge clk);
        #1;
        check("reset t_state", 32'(bus.t_state), 32'h01);
        check("reset halt", 32'(bus.halt), 32'h0);
        check("reset ctrl", 32'(obs_ctrl()), 32'h0);
        k      = 1;
        halted = 1'b0;

        // ADD interrupted by a 2-cycle reset during T5.
        for (int i = 0; i < 4; i++) tick(1'b0, ADD);
        check("mid-ADD at T5", 32'(bus.t_state), 32'h10);
        tick(1'b1, ADD);
        tick(1'b1, ADD);
        check("post-reset t_state", 32'(bus.t_state), 32'h01);
        check("post-reset halt", 32'(bus.halt), 32'h0);

        run_instr(LDA);
        run_instr(SUB);
        run_instr(ADD);
        run_instr(OUT);
        run_instr(HLT);
        check("halt set", 32'(bus.halt), 32'h1);
        for (int i = 0; i < 20; i++) tick(1'b0, HLT);
        check("halt frozen t_state", 32'(bus.t_state), 32'h10);
        tick(1'b1, HLT);
        check("halt cleared t_state", 32'(bus.t_state), 32'h01);
        check("halt cleared", 32'(bus.halt), 32'h0);

        for (int i = 0; i < 12; i++) tick(1'b0, UND);
        check("undefined no halt", 32'(bus.halt), 32'h0);
`ifdef CYCLE_SKIP_EN
        check("undefined period 4", 32'(bus.t_state), 32'h01);
`else
        check("undefined period 6", 32'(bus.t_state), 32'h01);
`endif

        // Random programs: opcode chosen at each T1, halts released by reset after a few cycles.
        op   = LDA;
        hcnt = 0;
        for (int i = 0; i < 1000; i++) begin
            bit r;
            if (k == 1 && !halted) begin
                case ($urandom_range(0, 5))
                    0: op = LDA;
                    1: op = ADD;
                    2: op = SUB;
                    3: op = OUT;
                    4: op = HLT;
                    default: op = 4'($urandom_range(0, 15));
                endcase
            end
            r = (halted && hcnt >= 3) || ($urandom_range(0, 63) == 0);
            tick(r, op);
            hcnt = halted ? hcnt + 1 : 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
